// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the memory stage.
// Accepts one request at a time (valid/ready), waits LATENCY cycles,
// then presents a response held until rsp_ready. Memory is an array of
// 32-bit words with byte-lane writes and is cleared by reset.
// Optional feature: define DMEM_ALIGN_CHECK_EN to fault misaligned
// word/halfword accesses.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; a response transfers on a rising edge where
// rsp_valid and rsp_ready are both 1. rsp_valid, rsp_rdata and rsp_err
// never change while rsp_valid=1 and rsp_ready=0.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  dbg_state_o
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q;
    logic [3:0]     cnt_q;
    logic           we_q;
    logic [AW-1:0]  idx_q;
    logic           fault_q;
    logic           rsp_valid_q;
    logic [31:0]    rsp_rdata_q;
    logic           rsp_err_q;
    logic [31:0]    mem_q [DEPTH_WORDS];

    logic           accept;
    logic [31:0]    word_idx;
    logic [AW-1:0]  req_idx;
    logic           out_of_range;
    logic           misaligned;
    logic           req_fault;
    logic [AW-1:0]  rd_idx;
    logic           rd_zero;
    logic [31:0]    rd_word;
    logic [31:0]    rdata_d;
    logic           unused_addr_bits;

    // Ready only while idle; forced low while reset is held.
    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    assign word_idx     = {2'b00, req_addr[31:2]};
    assign req_idx      = req_addr[AW+1:2];
    assign out_of_range = (word_idx >= 32'(DEPTH_WORDS));

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = ((req_be == 4'b1111) && (req_addr[1:0] != 2'b00)) ||
                        (((req_be == 4'b0011) || (req_be == 4'b1100)) && req_addr[0]);
`else
    assign misaligned = 1'b0;
`endif

    // Byte offset only matters to the optional alignment check.
    assign unused_addr_bits = ^req_addr[1:0];

    assign req_fault = out_of_range || misaligned;

    // Read port: the accepting request when LATENCY=1, otherwise the captured one.
    // Faulted accesses and stores return zero.
    assign rd_idx  = (state_q == IDLE) ? req_idx : idx_q;
    assign rd_zero = (state_q == IDLE) ? (req_we || req_fault) : (we_q || fault_q);
    assign rd_word = mem_q[rd_idx];
    assign rdata_d = rd_zero ? 32'd0 : rd_word;

    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign dbg_state_o = state_q;

    // Memory array: cleared on reset, store committed on the accepting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (accept && req_we && !req_fault) begin
            for (int b = 0; b < 4; b++) begin
                if (req_be[b]) begin
                    mem_q[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Request/latency/response FSM with registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            idx_q       <= '0;
            fault_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        idx_q   <= req_idx;
                        fault_q <= req_fault;
                        if (LATENCY <= 1) begin
                            state_q     <= RESP;
                            cnt_q       <= 4'd0;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= rdata_d;
                            rsp_err_q   <= req_fault;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q <= 4'd1) begin
                        state_q     <= RESP;
                        cnt_q       <= 4'd0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rdata_d;
                        rsp_err_q   <= fault_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= 4'd0;
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= 32'd0;
                    rsp_err_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_WORDS=256, LATENCY=2).
// Inputs change at negedge or #1 after posedge; outputs are read #1 after posedge.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_be      (req_be),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .dbg_state_o (dbg_state)
    );

    // Driver: wait (bounded) for req_ready, present request, return #1 after the accepting edge.
    task automatic send_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Driver: count edges (accepting edge = 1) until rsp_valid; 20 means no response.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Driver: complete the response handshake on the next edge.
    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rd, output logic er,
                        output int lat);
        send_req(we, addr, wdata, be);
        wait_rsp(lat);
        rd = rsp_rdata;
        er = rsp_err;
        ack_rsp();
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        er;
        int          lat;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 00000000", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready_held: got %b expected 0", req_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready_release: got %b expected 1", req_ready); end
        xact(1'b0, 32'h10, 32'h0, 4'b1111, rd, er, lat);
        checks++; if (rd !== 32'd0 || er !== 1'b0 || lat !== 2) begin errors++; $display("FAIL reset_mem_clear: rdata %h err %b lat %0d expected 00000000 0 2", rd, er, lat); end
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(1'b1, 32'h4, 32'hABCD1234, 4'b1111, rd, er, lat);
        checks++; if (rd !== 32'd0 || er !== 1'b0) begin errors++; $display("FAIL store_rsp: rdata %h err %b expected 00000000 0", rd, er); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL store_latency: got %0d expected 2", lat); end
        xact(1'b0, 32'h4, 32'h0, 4'b1111, rd, er, lat);
        checks++; if (rd !== 32'hABCD1234) begin errors++; $display("FAIL load_rdata: got %h expected abcd1234", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL load_err: got %b expected 0", er); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL load_latency: got %0d expected 2", lat); end
    endtask

    task automatic test_partial_store();
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(1'b1, 32'h8, 32'h87654321, 4'b1111, rd, er, lat);
        xact(1'b1, 32'h8, 32'h00AA0000, 4'b0100, rd, er, lat);
        checks++; if (er !== 1'b0 || lat !== 2) begin errors++; $display("FAIL partial_store_rsp: err %b lat %0d expected 0 2", er, lat); end
        xact(1'b0, 32'h8, 32'h0, 4'b0001, rd, er, lat);
        checks++; if (rd !== 32'h87AA4321) begin errors++; $display("FAIL partial_load: got %h expected 87aa4321", rd); end
        xact(1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== 32'd0 || lat !== 2) begin errors++; $display("FAIL be0_store_rsp: rdata %h err %b lat %0d expected 00000000 0 2", rd, er, lat); end
        xact(1'b0, 32'h8, 32'h0, 4'b1111, rd, er, lat);
        checks++; if (rd !== 32'h87AA4321) begin errors++; $display("FAIL be0_unchanged: got %h expected 87aa4321", rd); end
        xact(1'b1, 32'hC, 32'h11223344, 4'b1001, rd, er, lat);
        xact(1'b0, 32'hC, 32'h0, 4'b1111, rd, er, lat);
        checks++; if (rd !== 32'h11000044) begin errors++; $display("FAIL lanes_0_3: got %h expected 11000044", rd); end
    endtask

    task automatic test_backpressure();
        int lat;
        send_req(1'b0, 32'h4, 32'h0, 4'b1111);
        wait_rsp(lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL bp_latency: got %0d expected 2", lat); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp_valid, req_ready, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'hABCD1234}) begin
                errors++;
                $display("FAIL bp_hold_%0d: valid %b ready %b err %b rdata %h expected 1 0 0 abcd1234",
                         i, rsp_valid, req_ready, rsp_err, rsp_rdata);
            end
            @(posedge clk);
            #1;
        end
        ack_rsp();
        checks++;
        if ({rsp_valid, req_ready, rsp_err, rsp_rdata} !== {1'b1 ^ 1'b1, 1'b1, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL bp_release: valid %b ready %b err %b rdata %h expected 0 1 0 00000000",
                     rsp_valid, req_ready, rsp_err, rsp_rdata);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(1'b0, 32'h400, 32'h0, 4'b1111, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'd0 || lat !== 2) begin errors++; $display("FAIL oor_load: rdata %h err %b lat %0d expected 00000000 1 2", rd, er, lat); end
        xact(1'b1, 32'h400, 32'hFFFFFFFF, 4'b1111, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL oor_store: rdata %h err %b expected 00000000 1", rd, er); end
        xact(1'b0, 32'h0, 32'h0, 4'b1111, rd, er, lat);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL oor_word0: got %h expected 00000000", rd); end
        xact(1'b0, 32'h4, 32'h0, 4'b1111, rd, er, lat);
        checks++; if (rd !== 32'hABCD1234) begin errors++; $display("FAIL oor_word1: got %h expected abcd1234", rd); end
        xact(1'b1, 32'h3FC, 32'hCAFEF00D, 4'b1111, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL last_word_store_err: got %b expected 0", er); end
        xact(1'b0, 32'h3FC, 32'h0, 4'b1111, rd, er, lat);
        checks++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin errors++; $display("FAIL last_word_load: rdata %h err %b expected cafef00d 0", rd, er); end
        xact(1'b0, 32'hFFFFFFFC, 32'h0, 4'b1111, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL top_addr: rdata %h err %b expected 00000000 1", rd, er); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(1'b0, 32'h6, 32'h0, 4'b1111, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
        checks++; if (er !== 1'b1 || rd !== 32'd0 || lat !== 2) begin errors++; $display("FAIL misalign_word: rdata %h err %b lat %0d expected 00000000 1 2", rd, er, lat); end
`else
        checks++; if (er !== 1'b0 || rd !== 32'hABCD1234 || lat !== 2) begin errors++; $display("FAIL misalign_word: rdata %h err %b lat %0d expected abcd1234 0 2", rd, er, lat); end
`endif
        xact(1'b0, 32'h6, 32'h0, 4'b0011, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== 32'hABCD1234) begin errors++; $display("FAIL aligned_half: rdata %h err %b expected abcd1234 0", rd, er); end
    endtask

    task automatic test_reset_in_resp();
        int lat;
        send_req(1'b0, 32'h4, 32'h0, 4'b1111);
        wait_rsp(lat);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rst_resp_pre: got %b expected 1", rsp_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0) begin errors++; $display("FAIL rst_resp_async: valid %b rdata %h expected 0 00000000", rsp_valid, rsp_rdata); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd;
        logic        er;
        int          lat;
        // Store is committed on the accepting edge, then reset lands in WAIT.
        send_req(1'b1, 32'h4, 32'h5A5A5A5A, 4'b1111);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL rst_wait_now: valid %b ready %b expected 0 0", rsp_valid, req_ready); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_held: got %b expected 0", rsp_valid); end
        @(negedge clk);
        rst = 1'b0;
        xact(1'b0, 32'h4, 32'h0, 4'b1111, rd, er, lat);
        checks++; if (rd !== 32'd0 || er !== 1'b0 || lat !== 2) begin errors++; $display("FAIL rst_wait_load: rdata %h err %b lat %0d expected 00000000 0 2", rd, er, lat); end
        xact(1'b0, 32'h3FC, 32'h0, 4'b1111, rd, er, lat);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rst_clear_last: got %h expected 00000000", rd); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_partial_store();
        test_backpressure();
        test_out_of_range();
        test_misalign();
        test_reset_in_resp();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case a driver loop stalls outside its bounds.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
